// File: rtl/pll_lock_reset.sv
// pll_lock_reset: synchronises the raw PLL lock flag, sequences the fabric reset and keeps lock-loss debug status.
// Optional macro PLL_LOCK_TIMEOUT_EN adds a WAIT-state timeout that requests a PLL restart.
module pll_lock_reset #(
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_CYCLES    = 16,
    parameter int RST_HOLD       = 8,
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clki,
    input  logic             rsti,
    input  logic             locked_i,
    input  logic             clr_lost_i,
    output logic             rst_o,
    output logic             ready_o,
    output logic             lost_o,
    output logic [CNT_W-1:0] loss_cnt_o,
    output logic             pll_rst_o,
    output logic             timeout_o
);

    localparam int MAX_A = (LOCK_CYCLES > RST_HOLD) ? LOCK_CYCLES : RST_HOLD;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0]    HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0]    LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CNT_W-1:0] LOSS_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT,
        S_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk_s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rst_q, ready_q;
    logic                   lost_q, lost_d;
    logic [CNT_W-1:0]       loss_cnt_q, loss_cnt_d;
    logic                   loss_evt;

    assign lk_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clki or posedge rsti) begin
        if (rsti) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked_i};
        end
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    prst_q, prst_d;
    logic          tmo_q, tmo_d;
    logic          tmo_hit;
    logic          tmo_evt;

    assign tmo_hit = (state_q == S_WAIT) && (tcnt_q == TMO_LAST);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_evt = 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
        tmo_evt  = 1'b0;
`endif
        case (state_q)
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT: begin
                if (lk_s) begin
                    if (cnt_q == LOCK_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
`ifdef PLL_LOCK_TIMEOUT_EN
                // A lock completing on the timeout edge still wins.
                if (tmo_hit && (state_d != S_RUN)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    tmo_evt = 1'b1;
                end
`endif
            end
            S_RUN: begin
                if (!lk_s) begin
                    state_d  = S_HOLD;
                    cnt_d    = '0;
                    loss_evt = 1'b1;
                end
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear is applied before a coincident loss is counted.
    always_comb begin
        lost_d     = clr_lost_i ? 1'b0 : lost_q;
        loss_cnt_d = clr_lost_i ? '0 : loss_cnt_q;
        if (loss_evt) begin
            lost_d = 1'b1;
            if (loss_cnt_d != '1) begin
                loss_cnt_d = loss_cnt_d + LOSS_ONE;
            end
        end
    end

    always_ff @(posedge clki or posedge rsti) begin
        if (rsti) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            rst_q      <= 1'b1;
            ready_q    <= 1'b0;
            lost_q     <= 1'b0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_q      <= (state_d != S_RUN);
            ready_q    <= (state_d == S_RUN);
            lost_q     <= lost_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign rst_o      = rst_q;
    assign ready_o    = ready_q;
    assign lost_o     = lost_q;
    assign loss_cnt_o = loss_cnt_q;

`ifdef PLL_LOCK_TIMEOUT_EN
    always_comb begin
        tcnt_d = ((state_q == S_WAIT) && (state_d == S_WAIT)) ? tcnt_q + CNT_ONE : '0;
        prst_d = (prst_q != 3'd0) ? prst_q - 3'd1 : 3'd0;
        tmo_d  = clr_lost_i ? 1'b0 : tmo_q;
        if (tmo_evt) begin
            prst_d = 3'd4;
            tmo_d  = 1'b1;
        end
    end

    always_ff @(posedge clki or posedge rsti) begin
        if (rsti) begin
            tcnt_q <= '0;
            prst_q <= 3'd0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            prst_q <= prst_d;
            tmo_q  <= tmo_d;
        end
    end

    assign pll_rst_o = (prst_q != 3'd0);
    assign timeout_o = tmo_q;
`else
    assign pll_rst_o = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_reset.sv
// Directed bench for pll_lock_reset: release latency, glitch restart, loss status, saturation, async reset, timeout.
module tb_pll_lock_reset;

    logic       clki = 1'b0;
    logic       rsti;
    logic       locked_i;
    logic       clr_lost_i;
    logic       rst_o;
    logic       ready_o;
    logic       lost_o;
    logic [3:0] loss_cnt_o;
    logic       pll_rst_o;
    logic       timeout_o;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt;

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    always #5 clki = ~clki;

    pll_lock_reset #(
        .SYNC_STAGES   (2),
        .LOCK_CYCLES   (16),
        .RST_HOLD      (8),
        .CNT_W         (4),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clki      (clki),
        .rsti      (rsti),
        .locked_i  (locked_i),
        .clr_lost_i(clr_lost_i),
        .rst_o     (rst_o),
        .ready_o   (ready_o),
        .lost_o    (lost_o),
        .loss_cnt_o(loss_cnt_o),
        .pll_rst_o (pll_rst_o),
        .timeout_o (timeout_o)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clki);
        #1;
    endtask

    initial begin
        rsti       = 1'b1;
        locked_i   = 1'b1;
        clr_lost_i = 1'b0;
        #2;
        chk("reset_rst", rst_o, 1);
        chk("reset_ready", ready_o, 0);
        chk("reset_lost", lost_o, 0);
        chk("reset_cnt", loss_cnt_o, 0);
        chk("reset_pllrst", pll_rst_o, 0);
        chk("reset_tmo", timeout_o, 0);
        step(2);
        rsti = 1'b0;

        // Lock high from time 0: 8 HOLD edges then 16 counting edges.
        step(8);
        chk("hold_end_rst", rst_o, 1);
        step(15);
        chk("boot_e23_rst", rst_o, 1);
        chk("boot_e23_ready", ready_o, 0);
        step(1);
        chk("boot_e24_rst", rst_o, 0);
        chk("boot_e24_ready", ready_o, 1);

        // Loss in RUN: sampled at T, reset at T+2.
        locked_i = 1'b0;
        step(1);
        chk("loss_t_rst", rst_o, 0);
        step(1);
        chk("loss_t1_rst", rst_o, 0);
        step(1);
        chk("loss_t2_rst", rst_o, 1);
        chk("loss_t2_ready", ready_o, 0);
        chk("loss_t2_lost", lost_o, 1);
        chk("loss_t2_cnt", loss_cnt_o, 1);

        // Re-release: 18th edge counting the first sampling edge.
        step(12);
        locked_i = 1'b1;
        step(17);
        chk("relock_e17_rst", rst_o, 1);
        step(1);
        chk("relock_e18_rst", rst_o, 0);
        chk("relock_e18_ready", ready_o, 1);

        // Glitch at cnt=10 during WAIT restarts the count.
        locked_i = 1'b0;
        step(3);
        chk("loss2_rst", rst_o, 1);
        chk("loss2_cnt", loss_cnt_o, 2);
        step(12);
        locked_i = 1'b1;
        step(12);
        locked_i = 1'b0;
        step(1);
        locked_i = 1'b1;
        step(17);
        chk("glitch_hold_rst", rst_o, 1);
        step(1);
        chk("glitch_release_rst", rst_o, 0);
        chk("glitch_release_ready", ready_o, 1);

        clr_lost_i = 1'b1;
        step(1);
        clr_lost_i = 1'b0;
        chk("clr_lost", lost_o, 0);
        chk("clr_cnt", loss_cnt_o, 0);

        // 17 losses saturate the 4-bit counter at 15.
        for (int i = 1; i <= 17; i++) begin
            locked_i = 1'b0;
            step(3);
            exp_cnt = (i > 15) ? 15 : i;
            chk("sat_cnt", loss_cnt_o, exp_cnt[7:0]);
            step(12);
            locked_i = 1'b1;
            step(18);
        end
        chk("sat_ready", ready_o, 1);
        chk("sat_lost", lost_o, 1);

        // Clear coincident with the 18th loss edge.
        locked_i = 1'b0;
        step(2);
        clr_lost_i = 1'b1;
        step(1);
        clr_lost_i = 1'b0;
        chk("clr_loss_lost", lost_o, 1);
        chk("clr_loss_cnt", loss_cnt_o, 1);
        chk("clr_loss_rst", rst_o, 1);

        // Async reset between edges while in RUN.
        step(12);
        locked_i = 1'b1;
        step(18);
        chk("prerst_ready", ready_o, 1);
        #3;
        rsti = 1'b1;
        #1;
        chk("async_rst", rst_o, 1);
        chk("async_ready", ready_o, 0);
        chk("async_lost", lost_o, 0);
        chk("async_cnt", loss_cnt_o, 0);
        step(1);
        locked_i = 1'b0;
        rsti     = 1'b0;

        // Lock never arrives: WAIT entered at E8, timeout at E1032.
        step(1031);
        chk("tmo_e1031_tmo", timeout_o, 0);
        chk("tmo_e1031_pll", pll_rst_o, 0);
        chk("tmo_e1031_rst", rst_o, 1);
        step(1);
        chk("tmo_e1032_tmo", timeout_o, TMO_EN);
        chk("tmo_e1032_pll", pll_rst_o, TMO_EN);
        step(3);
        chk("tmo_e1035_pll", pll_rst_o, TMO_EN);
        step(1);
        chk("tmo_e1036_pll", pll_rst_o, 0);
        chk("tmo_e1036_tmo", timeout_o, TMO_EN);
        clr_lost_i = 1'b1;
        step(1);
        clr_lost_i = 1'b0;
        chk("tmo_clr", timeout_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
